// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The optional FETCH_PERF_CNT_EN build adds fetch/redirect counters to the top.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] JMP_ALWAYS = 2'b00;
  localparam logic [1:0] JMP_Z      = 2'b01;
  localparam logic [1:0] JMP_NZ     = 2'b10;
  localparam logic [1:0] JMP_N      = 2'b11;

  // Field positions counted down from INSTR_W (the MSB index of each field).
  localparam int OP_OFS    = 1;
  localparam int INST_OFS  = 3;
  localparam int IMMIN_OFS = 5;
  localparam int OP_W      = 2;
  localparam int INST_W    = 2;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the instruction-memory port and the decode-side port of fetch_sequencer.
// Handshakes: imem_req/imem_addr hold until imem_valid; instr/pc_out hold while dec_valid until dec_valid&dec_ready.
interface fetch_sequencer_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic [INSTR_W-1:0] instr;
  logic [1:0]         op;
  logic [1:0]         inst;
  logic               immin;
  logic [PC_W-1:0]    pc_out;
  logic               dec_valid;
  logic               dec_ready;
  logic               wpc;
  logic [1:0]         jmpF;
  logic               flag_z;
  logic               flag_n;
  logic [PC_W-1:0]    jmp_target;

  modport master (
    output imem_req, imem_addr, instr, op, inst, immin, pc_out, dec_valid,
    input  imem_rdata, imem_valid, dec_ready, wpc, jmpF, flag_z, flag_n, jmp_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, op, inst, immin, pc_out, dec_valid,
    output imem_rdata, imem_valid, dec_ready, wpc, jmpF, flag_z, flag_n, jmp_target
  );
endinterface

// File: rtl/fetch_sequencer_jump_cond_eval.sv
// Combinational evaluation of the jump condition selected by jmpF against the ALU flags.
module jump_cond_eval
  import fetch_pkg::*;
(
  input  logic [1:0] jmpF,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (jmpF)
      JMP_ALWAYS: take = 1'b1;
      JMP_Z:      take = flag_z;
      JMP_NZ:     take = ~flag_z;
      JMP_N:      take = flag_n;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem read at a time, holds the word for decode.
// Define FETCH_PERF_CNT_EN to add saturating fetch_count/redirect_count outputs.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(4)
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_sequencer_if.master     bus,
  output state_t                state_dbg
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           redirect_count
`endif
);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc;
  logic            take;
  logic            accept;
  logic            hs;

  jump_cond_eval u_cond (
    .jmpF   (bus.jmpF),
    .flag_z (bus.flag_z),
    .flag_n (bus.flag_n),
    .take   (take)
  );

  assign accept = (state == FETCH) && bus.imem_valid;
  assign hs     = (state == HOLD) && bus.dec_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   if (bus.imem_valid) state_nx = HOLD;
      HOLD:    if (bus.dec_ready)  state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dec_valid = 1'b0;
    case (state)
      FETCH:   bus.imem_req  = 1'b1;
      HOLD:    bus.dec_valid = 1'b1;
      default: ;
    endcase
  end

  // Jump inputs matter only in the handshake cycle; PC wraps silently.
  always_ff @(posedge clk) begin
    if (rst)     pc <= RESET_PC;
    else if (hs) pc <= (bus.wpc && take) ? bus.jmp_target : pc + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instr  <= '0;
      bus.pc_out <= '0;
    end else if (accept) begin
      bus.instr  <= bus.imem_rdata;
      bus.pc_out <= pc;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.op        = bus.instr[INSTR_W-OP_OFS -: OP_W];
  assign bus.inst      = bus.instr[INSTR_W-INST_OFS -: INST_W];
  assign bus.immin     = bus.instr[INSTR_W-IMMIN_OFS];
  assign state_dbg     = state;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (accept && (fetch_count != '1))
        fetch_count <= fetch_count + 32'd1;
      if (hs && bus.wpc && take && (redirect_count != '1))
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule
